// File: rtl/sram256x8_host_ctrl.sv
`timescale 1ns/1ps
// sram256x8_host_ctrl
// Initiator-side controller for the 256x8 bit-maskable SRAM macro.
//
// Host request channel (valid/ready): a request transfers on a rising edge
// where req_valid & req_ready are both 1. The host holds req_* stable while
// req_valid is 1 and req_ready is 0. req_ready may fall at any time and
// never depends on req_valid.
// Response channel (valid/ready): read data transfers on a rising edge where
// resp_valid & resp_ready are both 1. resp_valid and resp_rdata stay stable
// until that edge.
//
// Ports:
//   CLK, RESETN            clock (shared with the macro), async active-low reset
//   req_valid/req_ready    host request handshake
//   req_write              1 = masked write, 0 = read
//   req_addr/req_wdata     word address and write data
//   req_wmask              per-bit write enable, active high
//   resp_valid/resp_ready  read response handshake
//   resp_rdata             read data
//   clr_start              one-cycle request to clear the whole array
//   clr_busy               clear sequence in progress
//   clr_done               one-cycle pulse after the last clear write
//   sram_cen/gwen/wen      macro controls, active low
//   sram_a/sram_d          macro address and data in
//   sram_q                 macro data out (valid after the read edge)
//   dbg_state              {rd_inflight, fsm state (1 = CLEAR)}
module sram256x8_host_ctrl #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
  input  logic              CLK,
  input  logic              RESETN,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [DATA_W-1:0] req_wmask,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  input  logic              clr_start,
  output logic              clr_busy,
  output logic              clr_done,
  output logic              sram_cen,
  output logic              sram_gwen,
  output logic [DATA_W-1:0] sram_wen,
  output logic [ADDR_W-1:0] sram_a,
  output logic [DATA_W-1:0] sram_d,
  input  logic [DATA_W-1:0] sram_q,
  output logic [1:0]        dbg_state
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  localparam logic [ADDR_W-1:0] CNT_LAST = '1;

  state_t            state_q;
  state_t            state_d;
  logic              rd_inflight_q;
  logic              resp_valid_q;
  logic [DATA_W-1:0] resp_rdata_q;
  logic              clr_done_q;
  logic [ADDR_W-1:0] cnt_q;

  logic accept;
  logic clr_go;
  logic clr_last;
  logic resp_take;

  // A read in flight or an un-taken response blocks new requests, so the
  // single response register can never be overwritten. Gating with RESETN
  // keeps the host from seeing ready while the block is held in reset.
  assign req_ready = RESETN
                   & (state_q == ST_IDLE)
                   & ~clr_start
                   & ~rd_inflight_q
                   & (~resp_valid_q | resp_ready);

  assign accept    = req_valid & req_ready;
  // Clear only starts when no read is still waiting for its sram_q capture.
  assign clr_go    = clr_start & (state_q == ST_IDLE) & ~rd_inflight_q;
  assign clr_last  = (state_q == ST_CLEAR) & (cnt_q == CNT_LAST);
  assign resp_take = resp_valid_q & resp_ready;

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (clr_go) begin
          state_d = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        if (clr_last) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // SRAM pin drive. Pins default to the idle pattern; an access is either a
  // clear write or the request being accepted in this very cycle. RESETN
  // gating makes the idle pattern appear as soon as reset asserts.
  always_comb begin
    sram_cen  = 1'b1;
    sram_gwen = 1'b1;
    sram_wen  = '1;
    sram_a    = '0;
    sram_d    = '0;
    if (RESETN && (state_q == ST_CLEAR)) begin
      sram_cen  = 1'b0;
      sram_gwen = 1'b0;
      sram_wen  = '0;
      sram_a    = cnt_q;
      sram_d    = CLEAR_VAL;
    end else if (accept) begin
      sram_cen = 1'b0;
      sram_a   = req_addr;
      if (req_write) begin
        sram_gwen = 1'b0;
        sram_wen  = ~req_wmask;
        sram_d    = req_wdata;
      end
    end
  end

  // FSM state register
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Clear address counter; wraps back to 0 after the last word.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      cnt_q <= '0;
    end else if (clr_go) begin
      cnt_q <= '0;
    end else if (state_q == ST_CLEAR) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // clr_done is a registered copy of "last clear write this edge", so it is
  // high for exactly the one cycle after the final write.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      clr_done_q <= 1'b0;
    end else begin
      clr_done_q <= clr_last;
    end
  end

  // Read pipeline: the accept edge launches the macro read, the following
  // edge captures sram_q into the response register.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      rd_inflight_q <= 1'b0;
    end else begin
      rd_inflight_q <= accept & ~req_write;
    end
  end

  // A capture and a take on the same edge keep resp_valid high with new data.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
    end else if (rd_inflight_q) begin
      resp_valid_q <= 1'b1;
      resp_rdata_q <= sram_q;
    end else if (resp_take) begin
      resp_valid_q <= 1'b0;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign clr_busy   = (state_q == ST_CLEAR);
  assign clr_done   = clr_done_q;
  assign dbg_state  = {rd_inflight_q, state_q == ST_CLEAR};

endmodule
